add_seq_arbiter: RTL

ADD_SEQ_ARBITER -- requirements
Module: add_seq_arbiter

---
 rtl/add_seq_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/add_seq_arbiter.sv
// rtl/add_seq_arbiter.sv - round-robin arbiter feeding one time-shared 16-bit adder
//
// Adder16Bit : 16-bit carry-select adder slice (8-bit ripple low half,
//              duplicated high half selected by the low carry).
// add_seq_arbiter : NREQ requesters share one Adder16Bit; a granted W-bit add
//              (W = 16*WORDS) is performed one 16-bit slice per cycle, LSB first.
//
// Ports (add_seq_arbiter):
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid/req_ready      per-requester handshake, ready is one-hot or zero
//   req_a, req_b, req_cin    packed operands (requester i at [i*W +: W]) and carry-in
//   rsp_valid/rsp_ready      result handshake
//   rsp_id, rsp_sum, rsp_cout  owner index, W-bit sum, final carry-out
//   rsp_ovf                  two's-complement overflow, only when ADD_SEQ_OVF_EN is defined

module Adder16Bit (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);
  logic [8:0] lo;
  logic [8:0] hi0;
  logic [8:0] hi1;

  assign lo  = {1'b0, a_i[7:0]} + {1'b0, b_i[7:0]} + {8'b0, cin_i};
  // Both high-half outcomes are formed up front; the low carry only selects.
  assign hi0 = {1'b0, a_i[15:8]} + {1'b0, b_i[15:8]};
  assign hi1 = hi0 + 9'd1;

  assign sum_o[7:0]           = lo[7:0];
  assign {cout_o, sum_o[15:8]} = lo[8] ? hi1 : hi0;
endmodule

module add_seq_arbiter #(
  parameter int NREQ  = 4,
  parameter int WORDS = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*16*WORDS-1:0]    req_a,
  input  logic [NREQ*16*WORDS-1:0]    req_b,
  input  logic [NREQ-1:0]             req_cin,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(NREQ)-1:0]     rsp_id,
  output logic [16*WORDS-1:0]         rsp_sum,
`ifdef ADD_SEQ_OVF_EN
  output logic                        rsp_ovf,
`endif
  output logic                        rsp_cout
);
  localparam int W   = 16 * WORDS;
  localparam int IDW = $clog2(NREQ);
  localparam int SW  = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           carry_q, carry_d;
  logic [SW-1:0]  slice_q, slice_d;
`ifdef ADD_SEQ_OVF_EN
  logic           ovf_q, ovf_d;
`endif

  logic           grant_any;
  logic [IDW-1:0] grant_idx;
  logic           accept;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
  logic           sel_cin;
  logic [15:0]    slice_sum;
  logic           slice_cout;
  logic [W+15:0]  sum_cat;

  // Round-robin search: the lowest offset from rr_ptr with a valid request wins.
  always_comb begin
    int             cand;
    logic [IDW-1:0] cand_idx;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand     = (int'(rr_ptr_q) + off) % NREQ;
      cand_idx = cand[IDW-1:0];
      if (req_valid[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == i[IDW-1:0]) begin
        sel_a   = req_a[i*W +: W];
        sel_b   = req_b[i*W +: W];
        sel_cin = req_cin[i];
      end
    end
  end

  // Gated by rst_n so no requester sees an accept while reset is held.
  assign accept    = rst_n && (state_q == IDLE) && grant_any;
  assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;

  // Operands are shifted down each RUN cycle, so the active slice is always [15:0].
  Adder16Bit u_add (
    .a_i    (a_q[15:0]),
    .b_i    (b_q[15:0]),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  // Result slices enter at the top and shift down; after WORDS slices slice 0 is at the bottom.
  assign sum_cat = {slice_sum, sum_q};

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    slice_d  = slice_q;
`ifdef ADD_SEQ_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d      = sel_a;
          b_d      = sel_b;
          carry_d  = sel_cin;
          id_d     = grant_idx;
          slice_d  = '0;
          rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 16;
        b_d     = b_q >> 16;
        sum_d   = sum_cat[W+15:16];
        carry_d = slice_cout;
        slice_d = slice_q + 1'b1;
        if (slice_q == SW'(WORDS - 1)) begin
          state_d = DONE;
`ifdef ADD_SEQ_OVF_EN
          // Carry into the sign bit recovered from the sign-bit sum, xor carry-out.
          ovf_d   = (slice_sum[15] ^ a_q[15] ^ b_q[15]) ^ slice_cout;
`endif
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      slice_q  <= '0;
`ifdef ADD_SEQ_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      slice_q  <= slice_d;
`ifdef ADD_SEQ_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = carry_q;
  assign rsp_id    = id_q;
`ifdef ADD_SEQ_OVF_EN
  assign rsp_ovf   = ovf_q;
`endif
endmodule
